uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/uart_tx_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester / UART-transmitter bundle for uart_tx_sched.
// The master side holds the requesters and the transmitter; the slave side is the scheduler.
interface uart_tx_sched_if #(
  parameter int BYTES = 4
);
  localparam int W = 8 * BYTES;

  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req0_ack;
  logic         req1_ack;
  logic         grant;
  logic         busy;
  logic         tx_start;
  logic [7:0]   tx_din;
  logic         tx_done_tick;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_done_tick,
    input  req0_ack, req1_ack, grant, busy, tx_start, tx_din
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_done_tick,
    output req0_ack, req1_ack, grant, busy, tx_start, tx_din
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler serialising two requesters' BYTES-wide frames into a byte UART
// transmitter, LSB byte first, with a one-cycle ack per completed frame.
module uart_tx_sched #(
  parameter int BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_sched_if.slave  bus
);
  localparam int W = 8 * BYTES;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] shift_q, shift_d;
  logic [2:0]   count_q, count_d;
  logic         grant_q, grant_d;
  logic         last_grant_q, last_grant_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         tx_start_q, tx_start_d;
  logic [7:0]   tx_din_q, tx_din_d;

  logic [W-1:0] shift_nxt;
  logic         winner;

  assign shift_nxt = shift_q >> 8;

  // Lone valid wins; on contention the requester not served last time wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      winner = ~last_grant_q;
    end else if (bus.req1_valid) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    tx_start_d   = 1'b0;
    tx_din_d     = tx_din_q;

    unique case (state_q)
      IDLE: begin
        // An ack still showing means this is the ack cycle: no re-grant yet.
        if (!ack0_q && !ack1_q && (bus.req0_valid || bus.req1_valid)) begin
          grant_d    = winner;
          shift_d    = winner ? bus.req1_data : bus.req0_data;
          count_d    = 3'd0;
          tx_din_d   = winner ? bus.req1_data[7:0] : bus.req0_data[7:0];
          tx_start_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done_tick) begin
          if (count_q == 3'(BYTES - 1)) begin
            ack0_d       = ~grant_q;
            ack1_d       = grant_q;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            shift_d    = shift_nxt;
            count_d    = count_q + 3'd1;
            tx_din_d   = shift_nxt[7:0];
            tx_start_d = 1'b1;
            state_d    = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // tx_start/tx_din are registered on entry to SEND so they coincide with that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      count_q      <= 3'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_din_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      tx_start_q   <= tx_start_d;
      tx_din_q     <= tx_din_d;
    end
  end

  assign bus.req0_ack = ack0_q;
  assign bus.req1_ack = ack1_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_start = tx_start_q;
  assign bus.tx_din   = tx_din_q;
endmodule
